// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Steps a multi-cycle MIPS datapath through FETCH/DECODE/EXEC/MEM/WB for each
// instruction. The state, wait counter, halt cause and retired-instruction
// count are registered. The datapath strobes decode combinationally from the
// current state and the memory ready inputs. Reset forces every strobe low.
module multicycle_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_isLoad,
  input  logic             i_isStore,
  input  logic             i_regWe,
  input  logic             i_illegal,
  input  logic             i_imemRdy,
  input  logic             i_dmemRdy,
  output logic             o_imemReq,
  output logic             o_dmemReq,
  output logic             o_dmemWe,
  output logic             o_irWe,
  output logic             o_pcWe,
  output logic             o_regWe,
  output logic [2:0]       o_state,
  output logic             o_halted,
  output logic [1:0]       o_err,
  output logic [CNT_W-1:0] o_instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_IMEM_TO = 2'd2;
  localparam logic [1:0] ERR_DMEM_TO = 2'd3;

  // The counter only needs to reach TIMEOUT-1. A timeout fires when a
  // not-ready cycle would push it to TIMEOUT.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         err_q, err_d;
  logic [CNT_W-1:0]   instret_q;

  logic run;
  logic is_mem_op;
  logic timeout_hit;
  logic pc_we;

  assign run         = ~rst;
  assign is_mem_op   = i_isLoad | i_isStore;
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  // Strobes: decoded from the current state and the ready inputs. They are
  // gated by reset so that nothing is requested while reset is held.
  always_comb begin
    o_imemReq = run && (state_q == S_FETCH);
    o_irWe    = run && (state_q == S_FETCH) && i_imemRdy;
    o_dmemReq = run && (state_q == S_MEM);
    o_dmemWe  = run && (state_q == S_MEM) && i_isStore;
    o_regWe   = run && (state_q == S_WB);
    pc_we     = 1'b0;
    if (run) begin
      case (state_q)
        S_EXEC:  pc_we = ~is_mem_op & ~i_regWe;
        S_MEM:   pc_we = i_dmemRdy & i_isStore;
        S_WB:    pc_we = 1'b1;
        default: pc_we = 1'b0;
      endcase
    end
    o_pcWe = pc_we;
  end

  // Next-state logic: instruction sequencing, wait counting and halt causes.
  // A store has priority over a load when both are flagged. A ready that
  // arrives in the same cycle as the timeout is accepted.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH: begin
        if (i_imemRdy) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = ERR_IMEM_TO;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (i_illegal) begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wait_d = '0;
        if (is_mem_op) begin
          state_d = S_MEM;
        end else if (i_regWe) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (i_dmemRdy) begin
          wait_d  = '0;
          state_d = i_isStore ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = ERR_DMEM_TO;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        wait_d  = '0;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // State, wait counter, halt cause and retire counter registers.
  // The retire counter wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      err_q     <= ERR_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (pc_we) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign o_state   = state_q;
  assign o_halted  = (state_q == S_HALT);
  assign o_err     = err_q;
  assign o_instret = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer: directed instruction vectors push their
// expected retire/halt record into a scoreboard; a negedge monitor pops and
// compares whenever the DUT retires (o_pcWe) or enters HALT.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_isLoad = 1'b0, i_isStore = 1'b0, i_regWe = 1'b0, i_illegal = 1'b0;
  logic       i_imemRdy = 1'b0, i_dmemRdy = 1'b0;
  logic       o_imemReq, o_dmemReq, o_dmemWe, o_irWe, o_pcWe, o_regWe;
  logic [2:0] o_state;
  logic       o_halted;
  logic [1:0] o_err;
  logic [3:0] o_instret;

  multicycle_sequencer #(.CNT_W(4), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_isLoad  (i_isLoad),
    .i_isStore (i_isStore),
    .i_regWe   (i_regWe),
    .i_illegal (i_illegal),
    .i_imemRdy (i_imemRdy),
    .i_dmemRdy (i_dmemRdy),
    .o_imemReq (o_imemReq),
    .o_dmemReq (o_dmemReq),
    .o_dmemWe  (o_dmemWe),
    .o_irWe    (o_irWe),
    .o_pcWe    (o_pcWe),
    .o_regWe   (o_regWe),
    .o_state   (o_state),
    .o_halted  (o_halted),
    .o_err     (o_err),
    .o_instret (o_instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit   halt;
    int   cycles;
    int   st;
    int   reg_n;
    int   dreq_n;
    int   dwe_n;
    int   ir_n;
    int   err;
    int   cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   n_retired = 0;
  logic [3:0] exp_cnt = 4'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: per-instruction activity counters, compared at retire or halt.
  int   m_cyc, m_reg, m_dreq, m_dwe, m_ir;
  bit   m_halt_seen;
  bit   m_cnt_pending;
  int   m_cnt_exp;
  exp_t m_e;

  always @(negedge clk) begin
    if (rst) begin
      m_cyc = 0; m_reg = 0; m_dreq = 0; m_dwe = 0; m_ir = 0;
      m_halt_seen = 0; m_cnt_pending = 0;
    end else begin
      if (m_cnt_pending) begin
        chk("instret", int'(o_instret), m_cnt_exp);
        m_cnt_pending = 0;
      end
      if (o_halted) begin
        if (!m_halt_seen) begin
          m_halt_seen = 1;
          if (sb.size() == 0) begin
            chk("unexpected_halt", 1, 0);
          end else begin
            m_e = sb.pop_front();
            $display("halt: cycles=%0d err=%0d state=%0d", m_cyc, o_err, o_state);
            chk("event_is_halt", 1, int'(m_e.halt));
            chk("halt_cycles", m_cyc, m_e.cycles);
            chk("halt_state", int'(o_state), m_e.st);
            chk("halt_err", int'(o_err), m_e.err);
            chk("halt_ir_n", m_ir, m_e.ir_n);
            chk("halt_dreq_n", m_dreq, m_e.dreq_n);
            chk("halt_reg_n", m_reg, m_e.reg_n);
          end
        end
      end else begin
        if (o_regWe)   m_reg++;
        if (o_dmemReq) m_dreq++;
        if (o_dmemWe)  m_dwe++;
        if (o_irWe)    m_ir++;
        m_cyc++;
        if (o_pcWe) begin
          if (sb.size() == 0) begin
            chk("unexpected_retire", 1, 0);
          end else begin
            m_e = sb.pop_front();
            $display("retire: cycles=%0d state=%0d regWe=%0d dmemReq=%0d dmemWe=%0d irWe=%0d",
                     m_cyc, o_state, m_reg, m_dreq, m_dwe, m_ir);
            chk("event_is_retire", 0, int'(m_e.halt));
            chk("retire_cycles", m_cyc, m_e.cycles);
            chk("retire_state", int'(o_state), m_e.st);
            chk("retire_reg_n", m_reg, m_e.reg_n);
            chk("retire_dreq_n", m_dreq, m_e.dreq_n);
            chk("retire_dwe_n", m_dwe, m_e.dwe_n);
            chk("retire_ir_n", m_ir, m_e.ir_n);
            m_cnt_pending = 1;
            m_cnt_exp = m_e.cnt;
          end
          n_retired++;
          m_cyc = 0; m_reg = 0; m_dreq = 0; m_dwe = 0; m_ir = 0;
        end
      end
    end
  end

  // Issue one instruction: iw/dw are the number of not-ready cycles the
  // instruction/data memories insert before answering.
  task automatic run_instr(input bit ld, input bit st, input bit rw, input bit ill,
                           input int iw, input int dw, input bit halt, input int cyc,
                           input int est, input int rn, input int dq, input int dwn,
                           input int irn, input int err);
    exp_t e;
    int   start;
    int   iwl;
    int   dwl;
    bit   done;
    if (!halt) exp_cnt = exp_cnt + 4'd1;
    e.halt = halt; e.cycles = cyc; e.st = est; e.reg_n = rn; e.dreq_n = dq;
    e.dwe_n = dwn; e.ir_n = irn; e.err = err; e.cnt = int'(exp_cnt);
    sb.push_back(e);
    i_isLoad = ld; i_isStore = st; i_regWe = rw; i_illegal = ill;
    iwl = iw; dwl = dw; start = n_retired; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      i_imemRdy = (o_state == 3'd0) && (iwl == 0);
      if (o_state == 3'd0 && iwl > 0) iwl--;
      i_dmemRdy = (o_state == 3'd3) && (dwl == 0);
      if (o_state == 3'd3 && dwl > 0) dwl--;
      @(posedge clk); #1;
      if (n_retired != start || o_halted) done = 1;
    end
    if (!done) chk("wait_bound", 0, 1);
    i_illegal = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_imemReq", int'(o_imemReq), 0);
    chk("rst_state", int'(o_state), 0);
    chk("rst_instret", int'(o_instret), 0);
    chk("rst_err", int'(o_err), 0);
    chk("rst_halted", int'(o_halted), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 4'd0;
    #1;
    chk("imemReq_after_rst", int'(o_imemReq), 1);
  endtask

  initial begin
    int bad;
    bit reached;
    do_reset();

    //        ld st rw il iw dw halt cyc st  reg dq dwe ir err
    run_instr(0, 0, 1, 0, 0, 0, 0,   4,  4,  1,  0, 0,  1, 0);   // ALU
    run_instr(1, 0, 1, 0, 0, 3, 0,   8,  4,  1,  4, 0,  1, 0);   // load, 3 dmem waits
    run_instr(0, 1, 0, 0, 0, 0, 0,   4,  3,  0,  1, 1,  1, 0);   // store
    for (int i = 0; i < 10; i++)
      run_instr(0, 0, 0, 0, 0, 0, 0, 3,  2,  0,  0, 0,  1, 0);   // branches
    run_instr(0, 0, 1, 0, 1, 0, 0,   5,  4,  1,  0, 0,  1, 0);   // ALU, 1 imem wait
    run_instr(1, 1, 1, 0, 0, 2, 0,   6,  3,  0,  3, 3,  1, 0);   // load+store -> store
    run_instr(1, 0, 1, 0, 0, 0, 0,   5,  4,  1,  1, 0,  1, 0);   // load, 16th retire wraps
    run_instr(0, 0, 1, 1, 0, 0, 1,   2,  7,  0,  0, 0,  1, 1);   // illegal

    // HALT must hold with no retire strobes even with both memories ready.
    i_imemRdy = 1'b1; i_dmemRdy = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_state != 3'd7 || o_pcWe || !o_halted || o_err != 2'd1) bad++;
    end
    chk("halt_hold", bad, 0);
    chk("halt_instret", int'(o_instret), 0);

    do_reset();
    run_instr(0, 0, 1, 0, 100, 0, 1, 4,  7,  0,  0, 0,  0, 2);   // imem timeout
    do_reset();
    run_instr(0, 0, 1, 0, 3, 0, 0,   7,  4,  1,  0, 0,  1, 0);   // ready on 4th fetch cycle
    run_instr(1, 0, 1, 0, 0, 100, 1, 7,  7,  0,  4, 0,  1, 3);   // dmem timeout
    do_reset();

    // Reset pulsed while a load sits in MEM.
    i_isLoad = 1'b1; i_isStore = 1'b0; i_regWe = 1'b1;
    i_imemRdy = 1'b1; i_dmemRdy = 1'b0;
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      if (o_state == 3'd3) reached = 1;
      else begin @(posedge clk); #1; end
    end
    chk("reach_mem", int'(reached), 1);
    @(posedge clk); #1;
    chk("mem_req_before_rst", int'(o_dmemReq), 1);
    rst = 1'b1;
    #1;
    chk("dmemReq_on_rst", int'(o_dmemReq), 0);
    chk("state_on_rst", int'(o_state), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 4'd0;
    run_instr(0, 0, 0, 0, 0, 0, 0,   3,  2,  0,  0, 0,  1, 0);   // branch after recovery

    repeat (2) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
